// File: rtl/result_drain_packer.sv
// result_drain_packer
//   Drains a result buffer over a read_enable/valid/empty handshake and packs PACK
//   consecutive results into one wide word. The word leaves on a valid/ready stream.
// Ports:
//   clk, reset                  clock (rising edge), asynchronous active-high reset
//   start, num_words            job launch pulse and result count, latched in IDLE
//   result_buffer_out/_empty/_valid, result_buffer_read_enable   buffer read side
//   out_data, out_valid, out_ready, out_last                     packed output stream
//   busy, done, words_read      job status
module result_drain_packer #(
  parameter int unsigned RESULT_BUFFER_WIDTH = 16,
  parameter int unsigned PACK                = 4,
  parameter int unsigned COUNT_WIDTH         = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [COUNT_WIDTH-1:0]              num_words,
  input  logic [RESULT_BUFFER_WIDTH-1:0]      result_buffer_out,
  input  logic                                result_buffer_empty,
  input  logic                                result_buffer_valid,
  output logic                                result_buffer_read_enable,
  output logic [RESULT_BUFFER_WIDTH*PACK-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_last,
  output logic                                busy,
  output logic                                done,
  output logic [COUNT_WIDTH-1:0]              words_read
);

  localparam int unsigned W      = RESULT_BUFFER_WIDTH;
  localparam int unsigned LANE_W = $clog2(PACK + 1);
  localparam int unsigned IDX_W  = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_REST,
    S_EMIT,
    S_DONE
  } state_e;

  state_e                   state_q, state_d;
  logic [COUNT_WIDTH-1:0]   num_q, num_d;
  logic [COUNT_WIDTH-1:0]   words_read_q, words_read_d;
  logic [LANE_W-1:0]        lane_q, lane_d;
  logic [PACK-1:0][W-1:0]   pack_q, pack_d;
  logic                     rd_en_q, rd_en_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_last_q, out_last_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     fire;

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    words_read_d = words_read_q;
    lane_d       = lane_q;
    pack_d       = pack_q;
    fire         = (state_q == S_FETCH) && rd_en_q && result_buffer_valid;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_d        = num_words;
          words_read_d = '0;
          lane_d       = '0;
          pack_d       = '0;
          state_d      = (num_words == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (fire) begin
          pack_d[IDX_W'(lane_q)] = result_buffer_out;
          lane_d                 = lane_q + LANE_W'(1);
          words_read_d           = words_read_q + COUNT_WIDTH'(1);
          if ((lane_d == LANE_W'(PACK)) || (words_read_d == num_q)) begin
            state_d = S_EMIT;
          end else begin
            state_d = S_REST;
          end
        end
      end
      // One idle cycle so that consecutive pops are separate requests
      S_REST: state_d = S_FETCH;
      S_EMIT: begin
        // out_valid is always high in EMIT, so ready alone completes the handshake
        if (out_ready) begin
          pack_d  = '0;
          lane_d  = '0;
          state_d = out_last_q ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    rd_en_d     = (state_d == S_FETCH) && !result_buffer_empty;
    out_valid_d = (state_d == S_EMIT);
    out_last_d  = (state_d == S_EMIT) && (words_read_d == num_d);
    busy_d      = (state_d == S_FETCH) || (state_d == S_REST) || (state_d == S_EMIT);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      words_read_q <= '0;
      lane_q       <= '0;
      pack_q       <= '0;
      rd_en_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      words_read_q <= words_read_d;
      lane_q       <= lane_d;
      pack_q       <= pack_d;
      rd_en_q      <= rd_en_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign result_buffer_read_enable = rd_en_q;
  assign out_data                  = pack_q;
  assign out_valid                 = out_valid_q;
  assign out_last                  = out_last_q;
  assign busy                      = busy_q;
  assign done                      = done_q;
  assign words_read                = words_read_q;

endmodule
